// File: rtl/fetch_pkg.sv
// Shared types for the fetch -> decode path.
// Entry layout and control-flow opcodes.
package fetch_pkg;

  localparam int FB_XLEN = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [FB_XLEN-1:0] instr;
    logic [FB_XLEN-1:0] pc;
    logic [FB_XLEN-1:0] pc_4;
  } fetch_entry_t;

endpackage

// File: rtl/branch_predecode.sv
// Flags control-flow opcodes (branch, jal, jalr).
// Used by fetch_buffer when FETCH_BUFFER_PREDECODE_EN is defined.
module branch_predecode
  import fetch_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_ctrl
);

  always_comb begin
    is_ctrl = 1'b0;
    unique case (1'b1)
      (opcode == OPC_BRANCH): is_ctrl = 1'b1;
      (opcode == OPC_JAL):    is_ctrl = 1'b1;
      (opcode == OPC_JALR):   is_ctrl = 1'b1;
      default:                is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_buffer.sv
// In-order queue between fetch and decode with flush.
// FETCH_BUFFER_PREDECODE_EN adds a stored per-entry is_ctrl_out flag.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     valid_in,
  input  logic [XLEN-1:0]          instr_in,
  input  logic [XLEN-1:0]          pc_in,
  input  logic [XLEN-1:0]          pc_4_in,
  output logic                     ready_out,
  output logic                     valid_out,
  output logic [XLEN-1:0]          instr_out,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          pc_4_out,
  input  logic                     ready_in,
`ifdef FETCH_BUFFER_PREDECODE_EN
  output logic                     is_ctrl_out,
`endif
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;
  logic          push;
  logic          pop;

  assign ready_out = (count != FULL);
  assign valid_out = (count != '0);
  assign push      = valid_in & ready_out;
  assign pop       = valid_out & ready_in;
  assign count_out = count;

  always_comb begin
    wr_entry       = '0;
    wr_entry.instr = FB_XLEN'(instr_in);
    wr_entry.pc    = FB_XLEN'(pc_in);
    wr_entry.pc_4  = FB_XLEN'(pc_4_in);
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: outputs are gated by valid_out.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[wr_ptr] <= wr_entry;
  end

  assign head      = mem[rd_ptr];
  assign instr_out = valid_out ? XLEN'(head.instr) : '0;
  assign pc_out    = valid_out ? XLEN'(head.pc)    : '0;
  assign pc_4_out  = valid_out ? XLEN'(head.pc_4)  : '0;

`ifdef FETCH_BUFFER_PREDECODE_EN
  logic             ctrl_in;
  logic [DEPTH-1:0] ctrl_mem;

  branch_predecode u_predecode (
    .opcode  (instr_in[6:0]),
    .is_ctrl (ctrl_in)
  );

  always_ff @(posedge clk) begin
    if (!reset) ctrl_mem <= '0;
    else if (!flush && push) ctrl_mem[wr_ptr] <= ctrl_in;
  end

  assign is_ctrl_out = valid_out & ctrl_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: reset, fill, drain, stream,
// flush, mid-run reset and (with the macro) predecode.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        valid_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [31:0] pc_4_in;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
  logic        ready_in;
  logic [2:0]  count_out;
`ifdef FETCH_BUFFER_PREDECODE_EN
  logic        is_ctrl_out;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(4), .XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .valid_in  (valid_in),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .pc_4_in   (pc_4_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .instr_out (instr_out),
    .pc_out    (pc_out),
    .pc_4_out  (pc_4_out),
    .ready_in  (ready_in),
`ifdef FETCH_BUFFER_PREDECODE_EN
    .is_ctrl_out (is_ctrl_out),
`endif
    .count_out (count_out)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] ins, input logic [31:0] pc);
    valid_in = 1'b1;
    instr_in = ins;
    pc_in    = pc;
    pc_4_in  = pc + 32'd4;
  endtask

  initial begin
    reset    = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    instr_in = '0;
    pc_in    = '0;
    pc_4_in  = '0;
    ready_in = 1'b0;
    step();
    step();
    reset = 1'b1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_instr", instr_out, 32'd0);

    // Fill
    for (int i = 0; i < 4; i++) begin
      beat(32'h13, 32'(4 * i));
      step();
    end
    check("fill_count", 32'(count_out), 32'd4);
    check("fill_ready", 32'(ready_out), 32'd0);
    beat(32'h13, 32'h10);
    step();
    step();
    check("full_count", 32'(count_out), 32'd4);
    check("hold_pc", pc_out, 32'h0);
    check("hold_pc4", pc_4_out, 32'h4);
    check("hold_instr", instr_out, 32'h13);

    // Drain
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", pc_out, 32'(4 * i));
      check("drain_valid", 32'(valid_out), 32'd1);
      step();
    end
    check("drain_empty", 32'(valid_out), 32'd0);
    check("drain_count", 32'(count_out), 32'd0);
    check("drain_zero", pc_out, 32'd0);

    // Streaming, wraps pointers several times
    for (int k = 0; k < 20; k++) begin
      beat(32'h1000 + 32'(k), 32'h100 + 32'(4 * k));
      step();
      check("stream_count", 32'(count_out), 32'd1);
      check("stream_pc", pc_out, 32'h100 + 32'(4 * k));
      check("stream_instr", instr_out, 32'h1000 + 32'(k));
    end
    valid_in = 1'b0;
    step();
    check("stream_end", 32'(count_out), 32'd0);

    // Flush with concurrent push and pop
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(32'h13, 32'h20 + 32'(4 * i));
      step();
    end
    check("pre_flush", 32'(count_out), 32'd3);
    beat(32'h13, 32'h40);
    ready_in = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    valid_in = 1'b0;
    check("flush_count", 32'(count_out), 32'd0);
    check("flush_valid", 32'(valid_out), 32'd0);
    step();
    check("flush_drop", 32'(count_out), 32'd0);
    beat(32'h33, 32'h80);
    ready_in = 1'b0;
    step();
    valid_in = 1'b0;
    check("post_flush_pc", pc_out, 32'h80);
    check("post_flush_cnt", 32'(count_out), 32'd1);

    // Reset mid-operation
    beat(32'h13, 32'h84);
    step();
    valid_in = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_count", 32'(count_out), 32'd0);
    check("midrst_ready", 32'(ready_out), 32'd1);
    check("midrst_pc", pc_out, 32'd0);

`ifdef FETCH_BUFFER_PREDECODE_EN
    check("pd_empty", 32'(is_ctrl_out), 32'd0);
    beat(32'h6F, 32'h200);
    step();
    beat(32'h13, 32'h204);
    step();
    valid_in = 1'b0;
    check("pd_jal", 32'(is_ctrl_out), 32'd1);
    ready_in = 1'b1;
    step();
    check("pd_addi", 32'(is_ctrl_out), 32'd0);
    step();
    ready_in = 1'b0;
    beat(32'h63, 32'h300);
    step();
    valid_in = 1'b0;
    check("pd_branch", 32'(is_ctrl_out), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("pd_flush", 32'(is_ctrl_out), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
